// File: rtl/fft_serializer_pkg.sv
// Shared constants, state encodings and index helpers for the FFT output serializer.
package fft_serializer_pkg;
  localparam int NBINS = 16;
  localparam int DW    = 32;
  localparam int IDX_W = 4;

  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_state_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} rd_state_e;

  function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] idx);
    return {idx[0], idx[1], idx[2], idx[3]};
  endfunction
endpackage

// File: rtl/fft_serializer_if.sv
// Valid/ready bin stream leaving the serializer.
interface fft_serializer_if;
  import fft_serializer_pkg::*;
  logic [DW-1:0]    out_d;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (output out_d, out_idx, out_valid, out_last, input out_ready);
  modport slave  (input out_d, out_idx, out_valid, out_last, output out_ready);
endinterface

// File: rtl/fft_serializer_bank.sv
// One frame bank: parallel load of all bins, combinational indexed read.
module fft_serializer_bank
  import fft_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DW-1:0]    wr_data [NBINS],
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_data
);
  logic [DW-1:0] mem_r [NBINS];

  // bin storage, written whole-frame on load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBINS; i++) mem_r[i] <= {DW{1'b0}};
    end else if (load) begin
      for (int i = 0; i < NBINS; i++) mem_r[i] <= wr_data[i];
    end
  end

  assign rd_data = mem_r[rd_idx];
endmodule

// File: rtl/fft_serializer.sv
// Ping-pong frame capture with a valid/ready read FSM streaming one bin per beat.
module fft_serializer
  import fft_serializer_pkg::*;
#(
  parameter bit BITREV = 1'b0
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] fft_d0,  fft_d1,  fft_d2,  fft_d3,
  input  logic [DW-1:0] fft_d4,  fft_d5,  fft_d6,  fft_d7,
  input  logic [DW-1:0] fft_d8,  fft_d9,  fft_d10, fft_d11,
  input  logic [DW-1:0] fft_d12, fft_d13, fft_d14, fft_d15,
  input  logic          fft_valid,
  output logic          busy,
  output logic          overflow,
  input  logic          ovf_clr,
  fft_serializer_if.master out_if
);
  logic [DW-1:0]    fft_d_s [NBINS];
  logic [DW-1:0]    rd_data_s [2];
  bank_state_e      bank_st_r [2];
  bank_state_e      bank_st_nx_s [2];
  rd_state_e        state_r, state_nx_s;
  logic             wr_sel_r, rd_sel_r;
  logic [IDX_W-1:0] idx_r, idx_nx_s, rd_idx_s;
  logic [DW-1:0]    data_r, bank_rd_s;
  logic             valid_r, valid_nx_s, last_r, busy_r, ovf_r;
  logic [1:0]       load_s, free_s;
  logic             accept_s, release_s, capture_s, drop_s, load_out_s, rd_bank_s;

  assign fft_d_s = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                     fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  assign accept_s  = valid_r && out_if.out_ready;
  assign release_s = accept_s && (idx_r == 4'd15);
  assign free_s    = {release_s && rd_sel_r, release_s && !rd_sel_r};
  // a bank freed by this cycle's last-beat accept may be refilled in the same cycle
  assign capture_s = fft_valid && ((bank_st_r[wr_sel_r] == BANK_EMPTY) ||
                                   (release_s && (rd_sel_r == wr_sel_r)));
  assign drop_s    = fft_valid && !capture_s;
  assign load_s    = {capture_s && wr_sel_r, capture_s && !wr_sel_r};

  // bank occupancy next-state
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_nx_s[b] = bank_st_r[b];
      if (load_s[b]) bank_st_nx_s[b] = BANK_FULL;
      else if (free_s[b]) bank_st_nx_s[b] = BANK_EMPTY;
      else bank_st_nx_s[b] = bank_st_r[b];
    end
  end

  // read FSM next-state
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bank_st_r[rd_sel_r] == BANK_FULL) state_nx_s = ST_STREAM;
        else state_nx_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (release_s && (bank_st_r[~rd_sel_r] != BANK_FULL)) state_nx_s = ST_IDLE;
        else state_nx_s = ST_STREAM;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // read FSM outputs: next beat index, valid and which bank feeds the output mux
  always_comb begin
    idx_nx_s   = idx_r;
    valid_nx_s = valid_r;
    load_out_s = 1'b0;
    rd_bank_s  = rd_sel_r;
    case (state_r)
      ST_IDLE: begin
        idx_nx_s = 4'd0;
        if (bank_st_r[rd_sel_r] == BANK_FULL) begin
          valid_nx_s = 1'b1;
          load_out_s = 1'b1;
        end else begin
          valid_nx_s = 1'b0;
        end
      end
      ST_STREAM: begin
        if (release_s) begin
          rd_bank_s  = ~rd_sel_r;
          idx_nx_s   = 4'd0;
          valid_nx_s = (bank_st_r[~rd_sel_r] == BANK_FULL);
          load_out_s = (bank_st_r[~rd_sel_r] == BANK_FULL);
        end else if (accept_s) begin
          idx_nx_s   = idx_r + 4'd1;
          load_out_s = 1'b1;
        end else begin
          idx_nx_s = idx_r;
        end
      end
      default: begin
        idx_nx_s   = 4'd0;
        valid_nx_s = 1'b0;
      end
    endcase
  end

  assign rd_idx_s  = BITREV ? bitrev4(idx_nx_s) : idx_nx_s;
  assign bank_rd_s = rd_data_s[rd_bank_s];

  // all state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st_r[0] <= BANK_EMPTY;
      bank_st_r[1] <= BANK_EMPTY;
      state_r      <= ST_IDLE;
      wr_sel_r     <= 1'b0;
      rd_sel_r     <= 1'b0;
      idx_r        <= 4'd0;
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      data_r       <= {DW{1'b0}};
      busy_r       <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      bank_st_r[0] <= bank_st_nx_s[0];
      bank_st_r[1] <= bank_st_nx_s[1];
      state_r      <= state_nx_s;
      wr_sel_r     <= wr_sel_r ^ capture_s;
      rd_sel_r     <= rd_sel_r ^ release_s;
      idx_r        <= idx_nx_s;
      valid_r      <= valid_nx_s;
      last_r       <= valid_nx_s && (idx_nx_s == 4'd15);
      data_r       <= load_out_s ? bank_rd_s : data_r;
      busy_r       <= (bank_st_nx_s[0] == BANK_FULL) || (bank_st_nx_s[1] == BANK_FULL);
      if (drop_s) ovf_r <= 1'b1;
      else if (ovf_clr) ovf_r <= 1'b0;
      else ovf_r <= ovf_r;
    end
  end

  fft_serializer_bank u_bank0 (
    .clk(clk), .rst(rst), .load(load_s[0]), .wr_data(fft_d_s),
    .rd_idx(rd_idx_s), .rd_data(rd_data_s[0])
  );
  fft_serializer_bank u_bank1 (
    .clk(clk), .rst(rst), .load(load_s[1]), .wr_data(fft_d_s),
    .rd_idx(rd_idx_s), .rd_data(rd_data_s[1])
  );

  assign out_if.out_d     = data_r;
  assign out_if.out_idx   = idx_r;
  assign out_if.out_valid = valid_r;
  assign out_if.out_last  = last_r;
  assign busy             = busy_r;
  assign overflow         = ovf_r;
endmodule
